// File: rtl/switch_led_io_ctrl.sv
// -----------------------------------------------------------------------------
// switch_led_io_ctrl
//
// Purpose:
//   Board-I/O block called from HLS code. While running, it drives LEDR from SW
//   in one of four modes. It completes its start/finish handshake once the
//   operator presses and then releases the finish key.
//
// Optional feature:
//   KEY_DEBOUNCE_EN - when defined, each synchronised key must stay stable for
//   DEBOUNCE_CYCLES cycles before the change is accepted. When undefined,
//   the synchronised key value is used directly.
//
// Ports:
//   clk             in   1          clock
//   reset           in   1          asynchronous, active-high reset
//   clk2x           in   1          HLS interface clock, unused
//   clk1x_follower  in   1          HLS interface clock, unused
//   start           in   1          begin a run; only looked at in IDLE
//   mode            in   2          0 pass, 1 SW+1, 2 ~SW, 3 press count
//   SW              in   SW_WIDTH   switches
//   KEY             in   KEY_WIDTH  push buttons, active-low, asynchronous
//   LEDR            out  SW_WIDTH   registered LED drive
//   finish          out  1          registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module switch_led_io_ctrl #(
    parameter int SW_WIDTH        = 6,
    parameter int KEY_WIDTH       = 4,
    parameter int FINISH_KEY      = 3,
    parameter int COUNT_KEY       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk2x,
    input  logic                 clk1x_follower,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [SW_WIDTH-1:0]  SW,
    input  logic [KEY_WIDTH-1:0] KEY,
    output logic [SW_WIDTH-1:0]  LEDR,
    output logic                 finish
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HELD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [SW_WIDTH-1:0] SW_ONE = SW_WIDTH'(1);

    // The HLS wrapper supplies these clocks, but this block does not use them.
    logic unused_clks;
    assign unused_clks = clk2x ^ clk1x_follower;

    // -------------------------------------------------------------------------
    // Key path: 2-flop synchroniser, optional debounce, edge detection.
    // All key flops reset to 1 because a released key reads 1.
    // -------------------------------------------------------------------------
    logic [KEY_WIDTH-1:0] k_meta;
    logic [KEY_WIDTH-1:0] k_s;
    logic [KEY_WIDTH-1:0] k_a;
    logic [KEY_WIDTH-1:0] k_a_prev;
    logic [KEY_WIDTH-1:0] key_press;
    logic [KEY_WIDTH-1:0] key_release;

    // NOTE: sequential blocks use non-blocking (<=) so every flop samples
    // pre-edge values; with blocking (=), k_s would capture KEY in the same
    // cycle and the synchroniser would collapse to a single flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_meta <= '1;
            k_s    <= '1;
        end else begin
            k_meta <= KEY;
            k_s    <= k_meta;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic [DB_W-1:0] db_cnt [KEY_WIDTH];

    // Each key counts consecutive cycles in which k_s disagrees with k_a.
    // On the DEBOUNCE_CYCLES-th such cycle, the new level is accepted.
    // Any cycle with agreement (a bounce back) restarts that key's count.
    // NOTE: this counter array is small, and it is part of control state, so
    // it is reset. Unlike a data RAM, it must start from a known count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_a <= '1;
            for (int i = 0; i < KEY_WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                if (k_s[i] == k_a[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    k_a[i]    <= k_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;
                end
            end
        end
    end
`else
    assign k_a = k_s;

    // The debounce length only matters when the debounce counters exist.
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_a_prev <= '1;
        end else begin
            k_a_prev <= k_a;
        end
    end

    // A key is active-low, so a press is a 1->0 change and a release is 0->1.
    assign key_press   = k_a_prev & ~k_a;
    assign key_release = ~k_a_prev & k_a;

    // -------------------------------------------------------------------------
    // FSM: state register, next-state logic, output logic.
    // -------------------------------------------------------------------------
    state_t state;
    state_t next_state;
    logic   active;

    assign active = (state == RUN) || (state == HELD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first. Any
    // path that left it unassigned would infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start)                   next_state = RUN;
            RUN:  if (key_press[FINISH_KEY])   next_state = HELD;
            HELD: if (key_release[FINISH_KEY]) next_state = DONE;
            DONE:                              next_state = IDLE;
        endcase
    end

    logic [SW_WIDTH-1:0] cnt;
    logic [SW_WIDTH-1:0] cnt_d;
    logic [SW_WIDTH-1:0] led_d;
    logic                finish_d;

    always_comb begin
        led_d = LEDR;
        if (active) begin
            unique case (mode)
                2'd0: led_d = SW;
                2'd1: led_d = SW + SW_ONE;
                2'd2: led_d = ~SW;
                2'd3: led_d = cnt;
            endcase
        end

        // finish is registered, so it rises on the same edge that enters DONE.
        finish_d = (next_state == DONE);

        // A start clears the counter. Presses count only while a run is active.
        cnt_d = cnt;
        if (state == IDLE && start) begin
            cnt_d = '0;
        end else if (active && key_press[COUNT_KEY]) begin
            cnt_d = cnt + SW_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            LEDR   <= '0;
            finish <= 1'b0;
            cnt    <= '0;
        end else begin
            LEDR   <= led_d;
            finish <= finish_d;
            cnt    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_switch_led_io_ctrl.sv
module tb_switch_led_io_ctrl;

    localparam int SW_W  = 6;
    localparam int KEY_W = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int HOLD = 24;
`else
    localparam int HOLD = 4;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             clk2x = 1'b0;
    logic             clk1x_follower = 1'b0;
    logic             start;
    logic [1:0]       mode;
    logic [SW_W-1:0]  sw;
    logic [KEY_W-1:0] key;
    logic [SW_W-1:0]  ledr;
    logic             finish;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    switch_led_io_ctrl #(
        .SW_WIDTH        (SW_W),
        .KEY_WIDTH       (KEY_W),
        .FINISH_KEY      (3),
        .COUNT_KEY       (0),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk2x          (clk2x),
        .clk1x_follower (clk1x_follower),
        .start          (start),
        .mode           (mode),
        .SW             (sw),
        .KEY            (key),
        .LEDR           (ledr),
        .finish         (finish)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic press(input int idx);
        key[idx] = 1'b0;
        tick(HOLD);
        key[idx] = 1'b1;
        tick(HOLD);
    endtask

    // Waits a bounded time for the finish pulse, then checks that it lasts one cycle.
    task automatic wait_finish(input string tag);
        int n = 0;
        while (finish !== 1'b1 && n < HOLD * 4) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, finish}, 32'd1);
        tick(1);
        check({tag, "_one_cycle"}, {31'd0, finish}, 32'd0);
    endtask

    // Runs n cycles and requires that finish stays low throughout.
    task automatic quiet(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            tick(1);
            if (finish !== 1'b0) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic end_run(input string tag);
        key[3] = 1'b0;
        tick(HOLD);
        key[3] = 1'b1;
        wait_finish(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        sw    = '0;
        key   = '1;
        tick(3);
        check("reset_ledr", ledr, 0);
        check("reset_finish", {31'd0, finish}, 0);
        reset = 1'b0;
        tick(2);

        // T1: mode 1 wraps 0x3F to 0; finish follows press then release.
        sw   = 6'h3F;
        mode = 2'd1;
        start_run();
        tick(1);
        check("t1_wrap", ledr, 6'h00);
        key[3] = 1'b0;
        quiet("t1_no_finish_while_held", HOLD);
        key[3] = 1'b1;
        wait_finish("t1_finish");

        // T2: mode changes take effect on the next cycle; LEDR holds in IDLE.
        sw   = 6'h05;
        mode = 2'd2;
        start_run();
        tick(1);
        check("t2_invert", ledr, 6'h3A);
        mode = 2'd0;
        tick(1);
        check("t2_pass", ledr, 6'h05);
        mode = 2'd1;
        tick(1);
        check("t2_inc", ledr, 6'h06);
        end_run("t2_finish");
        sw = 6'h2A;
        tick(3);
        check("t2_hold_idle", ledr, 6'h06);

        // T3: press counter wraps at 64; start is ignored mid-run; a
        // simultaneous count and finish press both take effect.
        sw   = 6'h00;
        mode = 2'd3;
        start_run();
        tick(1);
        check("t3_cnt_start", ledr, 0);
        for (int i = 0; i < 35; i++) press(0);
        check("t3_cnt_35", ledr, 35);
        start_run();
        for (int i = 0; i < 29; i++) press(0);
        check("t3_cnt_wrap64", ledr, 0);
        for (int i = 0; i < 5; i++) press(0);
        check("t3_cnt_69", ledr, 5);
        key[0] = 1'b0;
        key[3] = 1'b0;
        tick(HOLD);
        check("t3_simul_count", ledr, 6);
        key = '1;
        wait_finish("t3_simul_finish");
        check("t3_hold_idle", ledr, 6);
        start_run();
        tick(1);
        check("t3_restart_clear", ledr, 0);
        end_run("t3_restart_finish");

`ifdef KEY_DEBOUNCE_EN
        // T4: a 10-cycle pulse is filtered out; 20 held + 20 released completes.
        mode = 2'd0;
        start_run();
        key[3] = 1'b0;
        tick(10);
        key[3] = 1'b1;
        quiet("t4_glitch_filtered", 40);
        key[3] = 1'b0;
        tick(20);
        key[3] = 1'b1;
        wait_finish("t4_debounced_finish");
`else
        // Without debounce, a one-cycle glitch counts as a press and a release.
        mode = 2'd0;
        start_run();
        key[3] = 1'b0;
        tick(1);
        key[3] = 1'b1;
        wait_finish("t4_glitch_event");
`endif

        // T5: reset in HELD clears outputs at once; a later release does nothing.
        sw   = 6'h15;
        mode = 2'd0;
        start_run();
        tick(1);
        check("t5_led_before", ledr, 6'h15);
        key[3] = 1'b0;
        tick(HOLD);
        #2;
        reset = 1'b1;
        #1;
        check("t5_reset_ledr", ledr, 0);
        check("t5_reset_finish", {31'd0, finish}, 0);
        tick(1);
        reset = 1'b0;
        tick(HOLD);
        key[3] = 1'b1;
        quiet("t5_no_finish_after_reset", HOLD * 2);

        // T6: finish key already down at start; it must be released and re-pressed.
        key[3] = 1'b0;
        tick(HOLD);
        start_run();
        quiet("t6_no_finish_held_through_start", HOLD);
        key[3] = 1'b1;
        quiet("t6_no_finish_first_release", HOLD * 2);
        end_run("t6_finish_after_repress");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
